// File: rtl/squash_wb_ctrl.sv
// Wishbone-controlled wrapper for a game core: holds it in reset, can override its pads,
// counts frames from vsync and raises a divided frame interrupt.
module squash_wb_ctrl #(
    parameter int unsigned NUM_IO    = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned FRAME_W   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] game_out,
    input  logic [NUM_IO-1:0] game_oeb,
    input  logic              game_vsync_i,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic              game_reset_n_o,
    output logic [2:0]        user_irq
);

    localparam int unsigned HI_W = NUM_IO - 32;

    localparam logic [5:0] OffCtrl  = 6'd0;
    localparam logic [5:0] OffOutLo = 6'd1;
    localparam logic [5:0] OffOutHi = 6'd2;
    localparam logic [5:0] OffOebLo = 6'd3;
    localparam logic [5:0] OffOebHi = 6'd4;
    localparam logic [5:0] OffFrame = 6'd5;
    localparam logic [5:0] OffDiv   = 6'd6;
    localparam logic [5:0] OffStat  = 6'd7;

    logic [2:0]         ctrl_q, ctrl_d;
    logic [31:0]        out_lo_q, out_lo_d;
    logic [HI_W-1:0]    out_hi_q, out_hi_d;
    logic [31:0]        oeb_lo_q, oeb_lo_d;
    logic [HI_W-1:0]    oeb_hi_q, oeb_hi_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]        irq_div_q, irq_div_d;
    logic [15:0]        div_cnt_q, div_cnt_d;
    logic               irq_stat_q, irq_stat_d;
    logic               vsync_q;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    logic        in_window, req, wr;
    logic [5:0]  offset;
    logic [31:0] wmask, rdata;
    logic        frame_evt, div_hit;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    assign in_window = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign offset    = wbs_adr_i[7:2];
    assign req       = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr        = req & wbs_we_i & in_window;
    assign wmask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign frame_evt = game_vsync_i & ~vsync_q & ctrl_q[0];
    assign div_hit   = (irq_div_q != 16'd0) && (div_cnt_q == irq_div_q - 16'd1);

    always_comb begin
        rdata = 32'd0;
        if (in_window) begin
            case (offset)
                OffCtrl:  rdata = {29'd0, ctrl_q};
                OffOutLo: rdata = out_lo_q;
                OffOutHi: rdata = 32'(out_hi_q);
                OffOebLo: rdata = oeb_lo_q;
                OffOebHi: rdata = 32'(oeb_hi_q);
                OffFrame: rdata = 32'(frame_cnt_q);
                OffDiv:   rdata = {16'd0, irq_div_q};
                OffStat:  rdata = {31'd0, irq_stat_q};
                default:  rdata = 32'd0;
            endcase
        end
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        out_lo_d    = out_lo_q;
        out_hi_d    = out_hi_q;
        oeb_lo_d    = oeb_lo_q;
        oeb_hi_d    = oeb_hi_q;
        frame_cnt_d = frame_cnt_q;
        irq_div_d   = irq_div_q;
        div_cnt_d   = div_cnt_q;
        irq_stat_d  = irq_stat_q;
        ack_d       = req;
        dat_d       = (req & ~wbs_we_i) ? rdata : 32'd0;

        if (frame_evt) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            if (irq_div_q != 16'd0) begin
                div_cnt_d = div_hit ? 16'd0 : div_cnt_q + 16'd1;
            end
        end

        if (wr) begin
            case (offset)
                OffCtrl:  ctrl_d   = (ctrl_q & ~wmask[2:0]) | (wbs_dat_i[2:0] & wmask[2:0]);
                OffOutLo: out_lo_d = (out_lo_q & ~wmask) | (wbs_dat_i & wmask);
                OffOutHi: out_hi_d = (out_hi_q & ~wmask[HI_W-1:0])
                                   | (wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0]);
                OffOebLo: oeb_lo_d = (oeb_lo_q & ~wmask) | (wbs_dat_i & wmask);
                OffOebHi: oeb_hi_d = (oeb_hi_q & ~wmask[HI_W-1:0])
                                   | (wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0]);
                OffFrame: frame_cnt_d = '0;
                OffDiv: begin
                    irq_div_d = (irq_div_q & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);
                    div_cnt_d = 16'd0;
                end
                OffStat: begin
                    if (wbs_sel_i[0] && wbs_dat_i[0]) irq_stat_d = 1'b0;
                end
                default: ;
            endcase
        end

        // A divider terminal count beats a coincident write-1-to-clear.
        if (frame_evt && div_hit) irq_stat_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ctrl_q      <= '0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            oeb_lo_q    <= '1;
            oeb_hi_q    <= '1;
            frame_cnt_q <= '0;
            irq_div_q   <= '0;
            div_cnt_q   <= '0;
            irq_stat_q  <= 1'b0;
            vsync_q     <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
            oeb_lo_q    <= oeb_lo_d;
            oeb_hi_q    <= oeb_hi_d;
            frame_cnt_q <= frame_cnt_d;
            irq_div_q   <= irq_div_d;
            div_cnt_q   <= div_cnt_d;
            irq_stat_q  <= irq_stat_d;
            vsync_q     <= game_vsync_i;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
        end
    end

    assign wbs_ack_o      = ack_q;
    assign wbs_dat_o      = dat_q;
    assign io_out         = ctrl_q[1] ? {out_hi_q, out_lo_q} : game_out;
    assign io_oeb         = ctrl_q[1] ? {oeb_hi_q, oeb_lo_q} : game_oeb;
    assign game_reset_n_o = ctrl_q[0];
    assign user_irq       = {2'b00, irq_stat_q & ctrl_q[2]};

endmodule

// File: tb/tb_squash_wb_ctrl.sv
// Directed bench for squash_wb_ctrl with hand-computed expectations.
module tb_squash_wb_ctrl;

    localparam int unsigned NUM_IO = 38;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       adr = 32'h0, wdat = 32'h0;
    logic              ack;
    logic [31:0]       rdat;
    logic [NUM_IO-1:0] game_out = 38'h12_3456_789A;
    logic [NUM_IO-1:0] game_oeb = 38'h0F_0F0F_0F0F;
    logic              vsync = 1'b0;
    logic [NUM_IO-1:0] io_out, io_oeb;
    logic              game_rst_n;
    logic [2:0]        user_irq;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] A_CTRL  = 32'h3000_0000;
    localparam logic [31:0] A_OUTLO = 32'h3000_0004;
    localparam logic [31:0] A_OUTHI = 32'h3000_0008;
    localparam logic [31:0] A_OEBLO = 32'h3000_000C;
    localparam logic [31:0] A_OEBHI = 32'h3000_0010;
    localparam logic [31:0] A_FRAME = 32'h3000_0014;
    localparam logic [31:0] A_DIV   = 32'h3000_0018;
    localparam logic [31:0] A_STAT  = 32'h3000_001C;

    always #5 clk = ~clk;

    squash_wb_ctrl #(.NUM_IO(NUM_IO)) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .game_out      (game_out),
        .game_oeb      (game_oeb),
        .game_vsync_i  (vsync),
        .io_out        (io_out),
        .io_oeb        (io_oeb),
        .game_reset_n_o(game_rst_n),
        .user_irq      (user_irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One Wishbone transfer; checks ack arrives exactly one cycle after the request and drops.
    task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, output logic [31:0] rd);
        int n;
        @(posedge clk); #1;
        adr = a; wdat = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        check("ack_latency", 64'(n), 64'd1);
        rd = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_pulse", 64'(ack), 64'd0);
        check("dat_idle", 64'(rdat), 64'd0);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(a, d, s, 1'b1, dummy);
    endtask

    task automatic wb_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(a, 32'h0, 4'hF, 1'b0, rd);
        check(tag, 64'(rd), 64'(exp));
    endtask

    task automatic vsync_pulse();
        @(posedge clk); #1; vsync = 1'b1;
        @(posedge clk); #1; vsync = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        check("rst_game_n", 64'(game_rst_n), 64'd0);
        check("rst_irq", 64'(user_irq), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_io_out", 64'(io_out), 64'(game_out));
        check("rst_io_oeb", 64'(io_oeb), 64'(game_oeb));
        rst_n = 1'b1;

        wb_read_check("rst_oeb_lo", A_OEBLO, 32'hFFFF_FFFF);
        wb_read_check("rst_oeb_hi", A_OEBHI, 32'h0000_003F);
        wb_read_check("rst_frame", A_FRAME, 32'h0);

        wb_write(A_OUTLO, 32'hFFFF_FFFF, 4'b0010);
        wb_read_check("sel_lane", A_OUTLO, 32'h0000_FF00);

        wb_write(A_CTRL, 32'h1, 4'hF);
        wb_read_check("ctrl_rb", A_CTRL, 32'h1);
        check("game_run", 64'(game_rst_n), 64'd1);

        wb_write(A_OUTLO, 32'hA5A5_A5A5, 4'hF);
        wb_write(A_OUTHI, 32'hFFFF_FFFF, 4'hF);
        wb_read_check("out_hi_mask", A_OUTHI, 32'h0000_003F);
        wb_write(A_OEBLO, 32'h0, 4'hF);
        wb_write(A_OEBHI, 32'h0, 4'hF);
        wb_write(A_CTRL, 32'h3, 4'hF);
        check("ovr_io_out", 64'(io_out), 64'h3F_A5A5_A5A5);
        check("ovr_io_oeb", 64'(io_oeb), 64'h0);
        wb_write(A_CTRL, 32'h1, 4'hF);
        check("pass_io_out", 64'(io_out), 64'(game_out));
        check("pass_io_oeb", 64'(io_oeb), 64'(game_oeb));

        wb_read_check("out_window", 32'h3000_0100, 32'h0);
        wb_read_check("unmapped", 32'h3000_0020, 32'h0);
        wb_write(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        wb_write(32'h2000_0004, 32'h0, 4'hF);
        wb_read_check("oow_ctrl", A_CTRL, 32'h1);
        wb_read_check("oow_outlo", A_OUTLO, 32'hA5A5_A5A5);

        wb_write(A_DIV, 32'h3, 4'hF);
        wb_write(A_CTRL, 32'h5, 4'hF);
        vsync_pulse();
        vsync_pulse();
        check("irq_pre", 64'(user_irq), 64'd0);
        vsync_pulse();
        check("irq_p3", 64'(user_irq), 64'd1);
        wb_read_check("stat_p3", A_STAT, 32'h1);
        wb_write(A_STAT, 32'h1, 4'hF);
        check("irq_w1c", 64'(user_irq), 64'd0);
        vsync_pulse();
        vsync_pulse();
        check("irq_p5", 64'(user_irq), 64'd0);
        // Pulse 6 lands on the same edge as a write-1-to-clear of IRQ_STAT.
        @(posedge clk); #1;
        vsync = 1'b1; adr = A_STAT; wdat = 32'h1; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        check("coinc_ack", 64'(ack), 64'd1);
        vsync = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("set_wins", 64'(user_irq), 64'd1);
        vsync_pulse();
        wb_read_check("frame7", A_FRAME, 32'd7);

        wb_write(A_CTRL, 32'h4, 4'hF);
        vsync_pulse();
        wb_read_check("stop_frame", A_FRAME, 32'd7);
        check("stop_irq", 64'(user_irq), 64'd1);
        wb_write(A_FRAME, 32'h0000_1234, 4'h1);
        wb_read_check("frame_clr", A_FRAME, 32'd0);
        wb_write(A_CTRL, 32'h5, 4'hF);
        for (int i = 0; i < 5; i++) vsync_pulse();

        // Reset lands while the read of FRAME_CNT is being acknowledged.
        @(posedge clk); #1;
        adr = A_FRAME; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_ack", 64'(ack), 64'd1);
        check("pre_rst_frame", 64'(rdat), 64'd5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 64'(ack), 64'd0);
        check("mid_rst_game_n", 64'(game_rst_n), 64'd0);
        check("mid_rst_irq", 64'(user_irq), 64'd0);
        check("mid_rst_io_oeb", 64'(io_oeb), 64'(game_oeb));
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_read_check("post_rst_frame", A_FRAME, 32'd0);
        wb_read_check("post_rst_oeb_lo", A_OEBLO, 32'hFFFF_FFFF);
        wb_read_check("post_rst_oeb_hi", A_OEBHI, 32'h0000_003F);
        wb_read_check("post_rst_ctrl", A_CTRL, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/squash_wb_ctrl.md
SQUASH_WB_CTRL -- requirements
Module: squash_wb_ctrl

Interface
REQ-001 SHALL have parameter NUM_IO, default 38, number of driven user IO pads; legal range 33..64.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, register window base; window is BASE_ADDR[31:8].
REQ-003 SHALL have parameter FRAME_W, default 16, frame counter width; legal range 8..32.
REQ-004 SHALL have port wb_clk_i, input, 1 bit, the single clock for all logic.
REQ-005 SHALL have port wb_rst_ni, input, 1 bit: reset is asynchronous and active-low.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i: inputs, 1 bit each, Wishbone classic strobe, cycle and write.
REQ-007 SHALL have ports wbs_sel_i (input, 4), wbs_adr_i (input, 32), wbs_dat_i (input, 32): byte selects, byte address, write data.
REQ-008 SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32): acknowledge and read data.
REQ-009 SHALL have ports game_out and game_oeb: inputs, NUM_IO each, pad drive and output-enable-bar from the game core.
REQ-010 SHALL have port game_vsync_i, input, 1 bit, game vertical sync, same clock domain.
REQ-011 SHALL have ports io_out and io_oeb: outputs, NUM_IO each, to the pads.
REQ-012 SHALL have port game_reset_n_o, output, 1 bit, active-low reset to the game core.
REQ-013 SHALL have port user_irq, output, 3 bits, interrupt lines.

Function
REQ-014 Registers, word offset = wbs_adr_i[7:2]: 0x00 CTRL, 0x04 OUT_LO, 0x08 OUT_HI, 0x0C OEB_LO, 0x10 OEB_HI, 0x14 FRAME_CNT, 0x18 IRQ_DIV, 0x1C IRQ_STAT.
REQ-015 CTRL bits: [0] game_run, [1] override, [2] irq_en; other bits read 0.
REQ-016 OUT_HI/OEB_HI SHALL implement only bits [NUM_IO-33:0]; unimplemented bits read 0, writes ignored.
REQ-017 Request = stb & cyc & !ack; wbs_ack_o SHALL assert exactly one cycle after a request and deassert the following cycle; single-cycle pulse, never two consecutive ack cycles.
REQ-018 Writes commit on the request cycle; each byte lane written only if its wbs_sel_i bit is 1.
REQ-019 wbs_dat_o SHALL be registered, valid while ack high, 0 otherwise.
REQ-020 Address outside window or unmapped offset: still acked; read returns 0; write ignored.
REQ-021 io_out = override ? {OUT_HI,OUT_LO}[NUM_IO-1:0] : game_out; io_oeb likewise from OEB regs or game_oeb; purely combinational mux.
REQ-022 game_reset_n_o SHALL equal CTRL.game_run, so the game core is held in reset until software sets bit 0.
REQ-023 Frame event = rising edge of game_vsync_i (registered previous sample) while game_run = 1.
REQ-024 FRAME_CNT (FRAME_W bits, zero-extended on read) SHALL increment by 1 per frame event, wrapping from all-ones to 0.
REQ-025 Any write to FRAME_CNT clears it; write coincident with a frame event yields 0.
REQ-026 Divider counter (16 bits): +1 per frame event; on reaching IRQ_DIV[15:0]-1 it resets to 0 and sets IRQ_STAT[0].
REQ-027 IRQ_DIV = 0 disables divider and IRQ_STAT setting; any write to IRQ_DIV resets divider counter to 0.
REQ-028 IRQ_STAT[0] is write-1-to-clear; a set event in the same cycle as a clear SHALL win (bit ends 1).
REQ-029 user_irq[0] = IRQ_STAT[0] & CTRL.irq_en; user_irq[2:1] = 0.
REQ-030 Clearing game_run SHALL not clear FRAME_CNT, divider, or IRQ_STAT; it only stops counting.

Reset
REQ-031 On wb_rst_ni low, asynchronously: CTRL, OUT_LO/HI, FRAME_CNT, IRQ_DIV, IRQ_STAT, divider, vsync history, wbs_ack_o, wbs_dat_o = 0; OEB_LO/HI = all ones (implemented bits).
REQ-032 Reset value consequences: game_reset_n_o = 0, user_irq = 0, io_out/io_oeb follow game_out/game_oeb.
REQ-033 Reset asserted mid-transaction SHALL drop ack immediately; no write commits after reset release without a new request.

Verification
REQ-034 Write CTRL=0x1, read back -> ack one cycle later, read 0x0000_0001, game_reset_n_o = 1.
REQ-035 OUT_LO=0xA5A5_A5A5, OUT_HI=0x3F, OEB_LO=0, OEB_HI=0, CTRL=0x3 -> io_out = 38'h3F_A5A5_A5A5, io_oeb = 0; CTRL=0x1 -> io_out = game_out.
REQ-036 Write 0xFFFF_FFFF sel=4'b0010 to OUT_LO after reset -> reads 0x0000_FF00.
REQ-037 IRQ_DIV=3, CTRL=0x5, 7 vsync pulses -> FRAME_CNT=7, IRQ_STAT[0] set after pulse 3, user_irq=3'b001; W1C coincident with pulse 6 -> bit stays 1.
REQ-038 Read 0x3000_0100 and write 0x2000_0000 -> both acked, read 0, no register changed.
REQ-039 Assert wb_rst_ni low during ack cycle with FRAME_CNT=5 -> ack 0, FRAME_CNT 0, OEB regs all ones, game_reset_n_o 0.
